// File: rtl/cdf_builder_pkg.sv
// cdf_builder_pkg: shared types and constants for the CDF builder.
//   BINS_PER_WORD/LANE_W/CDF_W : table word layout (4 lanes of 32 bits,
//                                20 significant bits per lane)
//   state_t                    : controller states
//   pack_cdf                   : places lane CDFs into a table word, upper
//                                12 bits of each lane forced to zero
package cdf_builder_pkg;

  localparam int unsigned BINS_PER_WORD = 4;
  localparam int unsigned LANE_W        = 32;
  localparam int unsigned CDF_W         = 20;
  localparam int unsigned WORD_W        = BINS_PER_WORD * LANE_W;
  localparam int unsigned ADDR_W        = 16;

  typedef logic [CDF_W-1:0]         cdf_t;
  typedef cdf_t [BINS_PER_WORD-1:0] cdf_vec_t;
  typedef logic [WORD_W-1:0]        word_t;
  typedef logic [ADDR_W-1:0]        addr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic word_t pack_cdf(input cdf_vec_t v);
    word_t w;
    w = '0;
    for (int unsigned i = 0; i < BINS_PER_WORD; i++) begin
      w[i*LANE_W +: CDF_W] = v[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/cdf_builder_if.sv
// cdf_builder_if: request, M1 histogram read port, M2 CDF write port and
// result signals of the CDF builder.
//   master : the builder (drives addresses, write strobe/data, results)
//   slave  : the environment (drives start and histogram read data)
interface cdf_builder_if;
  import cdf_builder_pkg::*;

  logic  start;
  addr_t M1_ReadAddress;
  word_t M1_ReadBus;
  logic  WriteEnable;
  addr_t CDF_MEMAddress;
  word_t CDF_MEMBus;
  cdf_t  CdfMin;
  cdf_t  divisor;
  logic  done;

  modport master (
    input  start, M1_ReadBus,
    output M1_ReadAddress, WriteEnable, CDF_MEMAddress, CDF_MEMBus,
           CdfMin, divisor, done
  );

  modport slave (
    output start, M1_ReadBus,
    input  M1_ReadAddress, WriteEnable, CDF_MEMAddress, CDF_MEMBus,
           CdfMin, divisor, done
  );

endinterface

// File: rtl/cdf_builder_lane_adder.sv
// cdf_lane_adder: combinational 4-lane prefix sum of one histogram word.
//   acc_i   : running CDF carried in from previous words
//   word_i  : histogram word, bin counts in the low 20 bits of each lane
//   cdf_o   : per-lane CDF, cdf_o[i] = acc_i + h_0 + ... + h_i (mod 2^20)
//   carry_o : CDF after the last lane, carried to the next word
module cdf_lane_adder
  import cdf_builder_pkg::*;
(
  input  cdf_t     acc_i,
  input  word_t    word_i,
  output cdf_vec_t cdf_o,
  output cdf_t     carry_o
);

  cdf_t run_sum;
  logic unused_hi;

  always_comb begin
    run_sum = acc_i;
    cdf_o   = '0;
    for (int unsigned i = 0; i < BINS_PER_WORD; i++) begin
      run_sum  = run_sum + word_i[i*LANE_W +: CDF_W];
      cdf_o[i] = run_sum;
    end
    carry_o = run_sum;
  end

  // Upper lane bits carry no count information.
  always_comb begin
    unused_hi = 1'b0;
    for (int unsigned i = 0; i < BINS_PER_WORD; i++) begin
      unused_hi = unused_hi ^ (^word_i[i*LANE_W+CDF_W +: LANE_W-CDF_W]);
    end
  end

endmodule

// File: rtl/cdf_builder.sv
// cdf_builder: streams NUM_WORDS histogram words from M1, writes the running
// CDF to M2 with a fixed two-cycle address-to-write latency, and reports the
// smallest nonzero CDF value and the normalisation divisor.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   cdf_if  : start request, M1 read port, M2 write port, CdfMin/divisor/done
module cdf_builder
  import cdf_builder_pkg::*;
#(
  parameter addr_t       HIST_BASE = 16'h0000,
  parameter addr_t       CDF_BASE  = 16'h0000,
  parameter int unsigned NUM_WORDS = 64
) (
  input logic          clock,
  input logic          reset_n,
  cdf_builder_if.master cdf_if
);

  state_t   state_q;
  addr_t    addr_q;
  addr_t    rd_cnt_q;
  addr_t    wr_cnt_q;
  logic     rvalid_q;   // M1_ReadBus holds a requested word this cycle
  logic     we_q;
  addr_t    waddr_q;
  word_t    wdata_q;
  cdf_t     acc_q;
  cdf_t     min_q;
  cdf_t     div_q;
  logic     done_q;

  cdf_vec_t cdf_d;
  cdf_t     acc_d;
  cdf_t     min_d;

  cdf_lane_adder u_adder (
    .acc_i   (acc_q),
    .word_i  (cdf_if.M1_ReadBus),
    .cdf_o   (cdf_d),
    .carry_o (acc_d)
  );

  // First nonzero lane in bin order wins; once latched it never changes.
  always_comb begin
    min_d = min_q;
    for (int unsigned i = 0; i < BINS_PER_WORD; i++) begin
      if (min_d == '0) begin
        min_d = cdf_d[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      addr_q   <= HIST_BASE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rvalid_q <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      acc_q    <= '0;
      min_q    <= '0;
      div_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= (state_q == S_READ);
      we_q     <= 1'b0;

      if (rvalid_q) begin
        we_q     <= 1'b1;
        waddr_q  <= CDF_BASE + wr_cnt_q;
        wdata_q  <= pack_cdf(cdf_d);
        acc_q    <= acc_d;
        min_q    <= min_d;
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (cdf_if.start) begin
            state_q  <= S_READ;
            addr_q   <= HIST_BASE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            acc_q    <= '0;
            min_q    <= '0;
          end
        end
        S_READ: begin
          if (rd_cnt_q == addr_t'(NUM_WORDS - 1)) begin
            state_q <= S_DRAIN;
          end else begin
            addr_q   <= addr_q + 16'd1;
            rd_cnt_q <= rd_cnt_q + 16'd1;
          end
        end
        S_DRAIN: begin
          // Finish once the last word is on the write port: acc is final.
          if (!rvalid_q && we_q) begin
            div_q   <= acc_q - min_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!cdf_if.start) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cdf_if.M1_ReadAddress = addr_q;
  assign cdf_if.WriteEnable    = we_q;
  assign cdf_if.CDF_MEMAddress = waddr_q;
  assign cdf_if.CDF_MEMBus     = wdata_q;
  assign cdf_if.CdfMin         = min_q;
  assign cdf_if.divisor        = div_q;
  assign cdf_if.done           = done_q;

endmodule

// File: tb/tb_cdf_builder.sv
// tb_cdf_builder: directed, table-driven bench for cdf_builder with an M1
// histogram memory model (one-cycle synchronous read) and an M2 write monitor.
module tb_cdf_builder;
  import cdf_builder_pkg::*;

  localparam addr_t HB = 16'h0100;
  localparam addr_t CB = 16'h0200;
  localparam int    NW = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   edges   = 0;
  int   nchecks = 0;
  int   nerrors = 0;

  word_t hist  [NW];
  word_t got   [NW];
  cdf_t  model [NW*4];

  typedef struct {
    int    pat;
    cdf_t  exp_min;
    cdf_t  exp_div;
    int    probe_idx;
    word_t probe_exp;
  } vec_t;
  vec_t vecs [5];

  cdf_builder_if bus ();

  cdf_builder #(
    .HIST_BASE (HB),
    .CDF_BASE  (CB),
    .NUM_WORDS (NW)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .cdf_if  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  always @(posedge clk) begin
    int idx;
    idx = int'(bus.M1_ReadAddress) - int'(HB);
    if (idx >= 0 && idx < NW) bus.M1_ReadBus <= hist[idx];
    else                      bus.M1_ReadBus <= '1;
  end

  task automatic check(input string name, input logic [127:0] got_v, input logic [127:0] exp_v);
    nchecks++;
    if (got_v !== exp_v) begin
      nerrors++;
      $display("FAIL %s: got %0h, expected %0h", name, got_v, exp_v);
    end
  endtask

  task automatic set_bin(input int b, input cdf_t v);
    hist[b/4][(b%4)*32 +: 20] = v;
  endtask

  task automatic load_pat(input int p);
    cdf_t run;
    for (int w = 0; w < NW; w++) hist[w] = '0;
    case (p)
      0: for (int b = 0; b < 64; b++) set_bin(b, 20'd1);
      1: begin
        set_bin(0, 20'd1); set_bin(1, 20'd2); set_bin(2, 20'd3);
        set_bin(3, 20'd4); set_bin(4, 20'd5);
      end
      2: set_bin(200, 20'd4096);
      4: begin
        for (int b = 0; b < 256; b++) set_bin(b, 20'd1000);
        for (int b = 0; b < 256; b++) hist[b/4][(b%4)*32+20 +: 12] = 12'hFFF;
      end
      default: ;
    endcase
    run = '0;
    for (int b = 0; b < 256; b++) begin
      run = run + hist[b/4][(b%4)*32 +: 20];
      model[b] = run;
    end
  endtask

  // Raises start and follows the run until done, bounded to 200 cycles.
  // Cycle numbers count from the edge that samples start (cycle 1 follows it).
  task automatic do_run(output int nw, output int first, output int last,
                        output int donec, output int order_err);
    int s;
    int cyc;
    int widx;
    nw = 0; first = -1; last = -1; donec = -1; order_err = 0;
    for (int w = 0; w < NW; w++) got[w] = '1;
    @(negedge clk);
    bus.start = 1'b1;
    s = edges;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cyc = edges - s;
      if (bus.WriteEnable) begin
        widx = int'(bus.CDF_MEMAddress) - int'(CB);
        if (widx != nw) order_err++;
        if (widx >= 0 && widx < NW) got[widx] = bus.CDF_MEMBus;
        if (first < 0) first = cyc;
        last = cyc;
        nw++;
      end
      if (bus.done) begin
        donec = cyc;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag, input vec_t v, input int nw, input int first,
                           input int last, input int donec, input int order_err);
    int bad;
    check({tag, " writes"},     nw,        64);
    check({tag, " first_wr"},   first,     3);
    check({tag, " last_wr"},    last,      66);
    check({tag, " done_cyc"},   donec,     67);
    check({tag, " wr_order"},   order_err, 0);
    check({tag, " CdfMin"},     bus.CdfMin,  v.exp_min);
    check({tag, " divisor"},    bus.divisor, v.exp_div);
    check({tag, " probe_word"}, got[v.probe_idx], v.probe_exp);
    bad = 0;
    for (int w = 0; w < NW; w++)
      for (int i = 0; i < 4; i++)
        if (got[w][i*32 +: 32] !== {12'h000, model[w*4+i]}) bad++;
    check({tag, " cdf_table_bad_lanes"}, bad, 0);
  endtask

  initial begin
    int nw, first, last, donec, oe, cnt_we, cnt_nd;
    logic found;

    vecs[0] = '{0, 20'd1,    20'd63,     15, 128'h00000040_0000003F_0000003E_0000003D};
    vecs[1] = '{1, 20'd1,    20'd14,     0,  128'h0000000A_00000006_00000003_00000001};
    vecs[2] = '{2, 20'd4096, 20'd0,      50, 128'h00001000_00001000_00001000_00001000};
    vecs[3] = '{3, 20'd0,    20'd0,      63, 128'h0};
    vecs[4] = '{4, 20'd1000, 20'd255000, 0,  128'h00000FA0_00000BB8_000007D0_000003E8};

    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst WriteEnable", bus.WriteEnable,    1'b0);
    check("rst done",        bus.done,           1'b0);
    check("rst CdfMin",      bus.CdfMin,         20'd0);
    check("rst divisor",     bus.divisor,        20'd0);
    check("rst M1_ReadAddr", bus.M1_ReadAddress, HB);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      load_pat(vecs[k].pat);
      do_run(nw, first, last, donec, oe);
      check_run($sformatf("vec%0d", k), vecs[k], nw, first, last, donec, oe);
      if (k == 1) check("vec1 word1", got[1], 128'h0000000F_0000000F_0000000F_0000000F);
      if (k == 2) check("vec2 word49", got[49], 128'h0);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d done_clear", k), bus.done, 1'b0);
    end

    // start held high after done must not re-trigger
    load_pat(0);
    do_run(nw, first, last, donec, oe);
    check_run("hold_run1", vecs[0], nw, first, last, donec, oe);
    cnt_we = 0; cnt_nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.WriteEnable) cnt_we++;
      if (!bus.done) cnt_nd++;
    end
    check("hold no_writes", cnt_we, 0);
    check("hold done_kept", cnt_nd, 0);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("hold done_clear", bus.done, 1'b0);
    do_run(nw, first, last, donec, oe);
    check_run("hold_run2", vecs[0], nw, first, last, donec, oe);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // reset asserted while word 30 is on the write port
    load_pat(0);
    @(negedge clk);
    bus.start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.WriteEnable && bus.CDF_MEMAddress == CB + 16'd30) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst found_word30", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst WriteEnable", bus.WriteEnable, 1'b0);
    check("midrst done",        bus.done,        1'b0);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt_we = 0; cnt_nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.WriteEnable) cnt_we++;
      if (bus.done) cnt_nd++;
    end
    check("midrst no_writes", cnt_we, 0);
    check("midrst no_done",   cnt_nd, 0);
    do_run(nw, first, last, donec, oe);
    check_run("midrst_rerun", vecs[0], nw, first, last, donec, oe);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
